mips_multicycle_ctrl: RTL and testbench

Multicycle main control FSM for the MIPS32 core. It sequences each instruction through fetch, decode, execute, memory and writeback cycles, and drives datapath enables and mux selects. It produces the 2-bit `alu_op` consumed directly by `alu_control`. It also stalls on a single-bit memory-ready handshake.

---
 rtl/mips_pkg.sv | 73 +++++++
 rtl/mips_ctrl_decode.sv | 86 ++++++++
 rtl/mips_multicycle_ctrl.sv | 111 +++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS32 multicycle core.
// Contents:
//   state_t  - 4-bit main-control state encoding
//   OP_*     - primary opcode values (instruction[31:26])
//   ALU_OP_* - 2-bit alu_op codes shared by the main control and alu_control
//   PC_SRC_*, ALU_B_* - datapath mux select codes
//   ctrl_t   - bundle of every control output driven by the main control
package mips_pkg;

   typedef enum logic [3:0] {
      S_RESET     = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXEC_R    = 4'd3,
      S_R_WB      = 4'd4,
      S_MEM_ADDR  = 4'd5,
      S_MEM_READ  = 4'd6,
      S_MEM_WB    = 4'd7,
      S_MEM_WRITE = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_EXEC_I    = 4'd11,
      S_I_WB      = 4'd12,
      S_TRAP      = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OP_IMM   = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] ALU_B_RT      = 2'b00;
   localparam logic [1:0] ALU_B_FOUR    = 2'b01;
   localparam logic [1:0] ALU_B_IMM     = 2'b10;
   localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal_op;
   } ctrl_t;

   // Immediate-arithmetic opcodes that share the EXEC_I / I_WB path.
   function automatic logic is_imm_op(input logic [5:0] op);
      return (op == OP_ADDI) || (op == OP_ORI) || (op == OP_ANDI) || (op == OP_SLTI);
   endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: combinational output decoder for the multicycle control.
// Ports:
//   state     in  current FSM state
//   opcode    in  instruction[31:26] (selects alu_op in EXEC_I)
//   mem_ready in  memory handshake (qualifies the FETCH enables)
//   ctrl      out full control bundle; all-zero for RESET and unused encodings
module mips_ctrl_decode
   import mips_pkg::*;
(
   input  state_t      state,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   output ctrl_t       ctrl
);

   always_comb begin
      // NOTE: assigning a default to every field first keeps this block free of
      // inferred latches and guarantees no output is left undriven in any state.
      ctrl = '0;
      unique case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = ALU_B_FOUR;
            ctrl.alu_op    = ALU_OP_ADD;
            ctrl.pc_source = PC_SRC_ALU;
            // IR and PC update only on the cycle the fetch completes.
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = ALU_B_IMM_SH2;   // precompute branch target
            ctrl.alu_op    = ALU_OP_ADD;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALU_B_RT;
            ctrl.alu_op    = ALU_OP_FUNCT;
         end
         S_R_WB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
         end
         S_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = ALU_B_RT;
            ctrl.alu_op        = ALU_OP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PC_SRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_SRC_JUMP;
         end
         S_EXEC_I: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.alu_op    = (opcode == OP_ADDI) ? ALU_OP_ADD : ALU_OP_IMM;
         end
         S_I_WB: begin
            ctrl.reg_write = 1'b1;
         end
         S_TRAP: begin
            ctrl.illegal_op = 1'b1;
         end
         default: ;   // RESET and unused encodings keep the all-zero bundle
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the MIPS32 multicycle core.
// Holds the state register and next-state logic; output decoding lives in
// mips_ctrl_decode.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode            instruction[31:26] from the instruction register
//   mem_ready         memory completes the access this cycle
//   pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
//   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op
//                     datapath enables and mux selects
//   illegal_op        an unsupported opcode was decoded (TRAP)
//   state             current state, for debug
module mips_multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic [1:0]         pc_source,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state
);

   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl;

   // Because outputs decode from state_q, pulling rst_n low forces RESET
   // and therefore drops every output to 0 without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RESET;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every
         // register samples pre-edge values regardless of block ordering.
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = S_RESET;   // unused encodings recover through RESET
      unique case (state_q)
         S_RESET:  state_d = S_FETCH;
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (opcode == OP_RTYPE)                      state_d = S_EXEC_R;
            else if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEM_ADDR;
            else if (opcode == OP_BEQ)                   state_d = S_BRANCH;
            else if (opcode == OP_J)                     state_d = S_JUMP;
            else if (is_imm_op(opcode))                  state_d = S_EXEC_I;
            else                                         state_d = S_TRAP;
         end
         S_EXEC_R:   state_d = S_R_WB;
         S_R_WB:     state_d = S_FETCH;
         S_MEM_ADDR: begin
            // IR is frozen here, so opcode is still LW or SW.
            if (opcode == OP_LW)      state_d = S_MEM_READ;
            else if (opcode == OP_SW) state_d = S_MEM_WRITE;
            else                      state_d = S_TRAP;
         end
         S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_BRANCH:    state_d = S_FETCH;
         S_JUMP:      state_d = S_FETCH;
         S_EXEC_I:    state_d = S_I_WB;
         S_I_WB:      state_d = S_FETCH;
         S_TRAP:      state_d = S_TRAP;   // only reset leaves TRAP
         default:     state_d = S_RESET;
      endcase
   end

   mips_ctrl_decode u_decode (
      .state     (state_q),
      .opcode    (opcode),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign pc_source     = ctrl.pc_source;
   assign iord          = ctrl.iord;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign reg_dst       = ctrl.reg_dst;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign illegal_op    = ctrl.illegal_op;
   assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed scoreboard bench for mips_multicycle_ctrl.
// Stimulus pushes the hand-computed expected {state, outputs} for each cycle;
// a monitor pops and compares on every falling edge.
module tb_mips_multicycle_ctrl;
   import mips_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
   logic [1:0] pc_source, alu_src_b, alu_op;
   logic [3:0] state;

   int n_checks = 0;
   int n_fail   = 0;
   int step     = 0;

   // Expected output vectors, field order:
   // pw pwc ps[2] iord mr mw irw rd m2r rw asa asb[2] aop[2] ill
   localparam logic [16:0] E_ZERO      = 17'b0_0_00_0_0_0_0_0_0_0_0_00_00_0;
   localparam logic [16:0] E_FETCH_RDY = 17'b1_0_00_0_1_0_1_0_0_0_0_01_00_0;
   localparam logic [16:0] E_FETCH_WT  = 17'b0_0_00_0_1_0_0_0_0_0_0_01_00_0;
   localparam logic [16:0] E_DECODE    = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_0;
   localparam logic [16:0] E_EXEC_R    = 17'b0_0_00_0_0_0_0_0_0_0_1_00_10_0;
   localparam logic [16:0] E_R_WB      = 17'b0_0_00_0_0_0_0_1_0_1_0_00_00_0;
   localparam logic [16:0] E_MEM_ADDR  = 17'b0_0_00_0_0_0_0_0_0_0_1_10_00_0;
   localparam logic [16:0] E_MEM_READ  = 17'b0_0_00_1_1_0_0_0_0_0_0_00_00_0;
   localparam logic [16:0] E_MEM_WB    = 17'b0_0_00_0_0_0_0_0_1_1_0_00_00_0;
   localparam logic [16:0] E_MEM_WRITE = 17'b0_0_00_1_0_1_0_0_0_0_0_00_00_0;
   localparam logic [16:0] E_BRANCH    = 17'b0_1_01_0_0_0_0_0_0_0_1_00_01_0;
   localparam logic [16:0] E_JUMP      = 17'b1_0_10_0_0_0_0_0_0_0_0_00_00_0;
   localparam logic [16:0] E_EXEC_ADD  = 17'b0_0_00_0_0_0_0_0_0_0_1_10_00_0;
   localparam logic [16:0] E_EXEC_IMM  = 17'b0_0_00_0_0_0_0_0_0_0_1_10_11_0;
   localparam logic [16:0] E_I_WB      = 17'b0_0_00_0_0_0_0_0_0_1_0_00_00_0;
   localparam logic [16:0] E_TRAP      = 17'b0_0_00_0_0_0_0_0_0_0_0_00_00_1;

   typedef struct packed {
      logic [15:0] id;
      logic [3:0]  st;
      logic [16:0] vec;
   } exp_t;

   exp_t sb[$];

   mips_multicycle_ctrl #(.STATE_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_source     (pc_source),
      .iord          (iord),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .illegal_op    (illegal_op),
      .state         (state)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] outs();
      return {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
              reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op};
   endfunction

   task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: state got %0d exp %0d, outputs got %b exp %b",
                  name, got[20:17], exp[20:17], got[16:0], exp[16:0]);
      end
   endtask

   // One clock cycle: after the edge, drive inputs and enqueue the expectation.
   task automatic cyc(input logic [5:0] op, input logic rdy, input state_t st,
                      input logic [16:0] vec);
      exp_t e;
      @(posedge clk);
      #1;
      opcode    = op;
      mem_ready = rdy;
      e.id  = 16'(step);
      e.st  = st;
      e.vec = vec;
      sb.push_back(e);
      step++;
   endtask

   // Monitor: compare on every falling edge where an expectation is pending.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("step%0d", e.id), {state, outs()}, {e.st, e.vec});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held for three cycles: everything 0.
      repeat (3) cyc(6'b0, 1'b0, S_RESET, E_ZERO);
      @(negedge clk); #1 rst_n = 1'b1;

      // First edge after release lands in FETCH; one fetch wait state.
      cyc(OP_RTYPE, 1'b0, S_FETCH, E_FETCH_WT);
      cyc(OP_RTYPE, 1'b1, S_FETCH, E_FETCH_RDY);
      // R-type: 4 cycles.
      cyc(OP_RTYPE, 1'b1, S_DECODE, E_DECODE);
      cyc(OP_RTYPE, 1'b1, S_EXEC_R, E_EXEC_R);
      cyc(OP_RTYPE, 1'b1, S_R_WB,   E_R_WB);

      // LW with two memory stall cycles: 7 cycles.
      cyc(OP_LW, 1'b1, S_FETCH,    E_FETCH_RDY);
      cyc(OP_LW, 1'b1, S_DECODE,   E_DECODE);
      cyc(OP_LW, 1'b1, S_MEM_ADDR, E_MEM_ADDR);
      cyc(OP_LW, 1'b0, S_MEM_READ, E_MEM_READ);
      cyc(OP_LW, 1'b0, S_MEM_READ, E_MEM_READ);
      cyc(OP_LW, 1'b1, S_MEM_READ, E_MEM_READ);
      cyc(OP_LW, 1'b1, S_MEM_WB,   E_MEM_WB);

      // SW with one stall cycle.
      cyc(OP_SW, 1'b1, S_FETCH,     E_FETCH_RDY);
      cyc(OP_SW, 1'b1, S_DECODE,    E_DECODE);
      cyc(OP_SW, 1'b1, S_MEM_ADDR,  E_MEM_ADDR);
      cyc(OP_SW, 1'b0, S_MEM_WRITE, E_MEM_WRITE);
      cyc(OP_SW, 1'b1, S_MEM_WRITE, E_MEM_WRITE);

      // ORI: immediate alu_op.
      cyc(OP_ORI, 1'b1, S_FETCH,  E_FETCH_RDY);
      cyc(OP_ORI, 1'b1, S_DECODE, E_DECODE);
      cyc(OP_ORI, 1'b1, S_EXEC_I, E_EXEC_IMM);
      cyc(OP_ORI, 1'b1, S_I_WB,   E_I_WB);
      // ADDI: add alu_op.
      cyc(OP_ADDI, 1'b1, S_FETCH,  E_FETCH_RDY);
      cyc(OP_ADDI, 1'b1, S_DECODE, E_DECODE);
      cyc(OP_ADDI, 1'b1, S_EXEC_I, E_EXEC_ADD);
      cyc(OP_ADDI, 1'b1, S_I_WB,   E_I_WB);
      // SLTI.
      cyc(OP_SLTI, 1'b1, S_FETCH,  E_FETCH_RDY);
      cyc(OP_SLTI, 1'b1, S_DECODE, E_DECODE);
      cyc(OP_SLTI, 1'b1, S_EXEC_I, E_EXEC_IMM);
      cyc(OP_SLTI, 1'b1, S_I_WB,   E_I_WB);

      // BEQ and J: 3 cycles each.
      cyc(OP_BEQ, 1'b1, S_FETCH,  E_FETCH_RDY);
      cyc(OP_BEQ, 1'b1, S_DECODE, E_DECODE);
      cyc(OP_BEQ, 1'b1, S_BRANCH, E_BRANCH);
      cyc(OP_J,   1'b1, S_FETCH,  E_FETCH_RDY);
      cyc(OP_J,   1'b1, S_DECODE, E_DECODE);
      cyc(OP_J,   1'b1, S_JUMP,   E_JUMP);

      // Illegal opcode: TRAP is absorbing, even with legal opcodes afterwards.
      cyc(6'b111111, 1'b1, S_FETCH,  E_FETCH_RDY);
      cyc(6'b111111, 1'b1, S_DECODE, E_DECODE);
      for (int i = 0; i < 10; i++)
         cyc((i < 5) ? 6'b111111 : OP_RTYPE, i[0], S_TRAP, E_TRAP);

      // Mid-cycle reset: outputs drop without a clock edge.
      @(negedge clk); #2 rst_n = 1'b0;
      #1 check("async_rst", {state, outs()}, {S_RESET, E_ZERO});
      cyc(OP_RTYPE, 1'b1, S_RESET, E_ZERO);
      cyc(OP_RTYPE, 1'b1, S_RESET, E_ZERO);
      @(negedge clk); #1 rst_n = 1'b1;

      // Recovery: a full J after reset release.
      cyc(OP_J, 1'b1, S_FETCH,  E_FETCH_RDY);
      cyc(OP_J, 1'b1, S_DECODE, E_DECODE);
      cyc(OP_J, 1'b1, S_JUMP,   E_JUMP);
      cyc(OP_J, 1'b1, S_FETCH,  E_FETCH_RDY);

      // Let the monitor drain the scoreboard, bounded.
      for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
